// File: rtl/day_night_scheduler.sv
// rtl/day_night_scheduler.sv - score-driven day/night fade sequencer for the VGA colour-inversion stage
// Optional manual trigger input force_night is built when DAY_NIGHT_FORCE_EN is defined.
module day_night_scheduler #(
    parameter int PERIOD    = 700,
    parameter int NIGHT_LEN = 150,
    parameter int DIV_BITS  = 23,
    parameter int LEVEL_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] game_score,
    input  logic        pause,
`ifdef DAY_NIGHT_FORCE_EN
    input  logic        force_night,
`endif
    output logic [3:0]  fade_level,
    output logic        night,
    output logic        fading,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_DAY,
        ST_FADE_TO_NIGHT,
        ST_NIGHT,
        ST_FADE_TO_DAY
    } state_t;

    localparam int          LMAX_C      = (LEVEL_MAX > 15) ? 15 : ((LEVEL_MAX < 1) ? 1 : LEVEL_MAX);
    localparam logic [3:0]  LVL_MAX     = 4'(LMAX_C);
    localparam logic [14:0] PERIOD_V    = 15'(PERIOD);
    localparam logic [14:0] NIGHT_LEN_V = 15'(NIGHT_LEN);

    state_t              state_q, state_d;
    logic [3:0]          level_q, level_d;
    logic [14:0]         next_onset_q, next_onset_d;
    logic [14:0]         night_end_q, night_end_d;
    logic                pending_q, pending_d;
    logic                done_q, done_d;
    logic                entry_q, entry_d;
    logic [DIV_BITS-1:0] prescaler_q, prescaler_d;

    logic [14:0] score15;
    logic        restart;
    logic        tick;
    logic        onset_hit;
    logic        end_hit;
    logic        trig_force;

    // Saturating add keeps onset bookkeeping from wrapping back into the live score range.
    function automatic logic [14:0] sat_add(input logic [14:0] a, input logic [14:0] b);
        logic [15:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15] ? 15'h7fff : s[14:0];
    endfunction

    assign score15     = {1'b0, game_score};
    assign restart     = (game_score == 14'd0);
    assign tick        = (&prescaler_q) && !pause;
    assign onset_hit   = !restart && (score15 >= next_onset_q);
    assign end_hit     = (score15 >= night_end_q);
    assign prescaler_d = prescaler_q + 1'b1;

`ifdef DAY_NIGHT_FORCE_EN
    logic force_prev_q;
    assign trig_force = force_night && !force_prev_q && !pause && !restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) force_prev_q <= 1'b0;
        else        force_prev_q <= force_night;
    end
`else
    assign trig_force = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        next_onset_d = next_onset_q;
        night_end_d  = night_end_q;
        pending_d    = pending_q;
        done_d       = 1'b0;

        if (restart) begin
            state_d      = ST_DAY;
            level_d      = 4'd0;
            next_onset_d = PERIOD_V;
            pending_d    = 1'b0;
        end else begin
            case (state_q)
                ST_DAY: begin
                    if (!pause && (pending_q || onset_hit)) begin
                        state_d      = ST_FADE_TO_NIGHT;
                        night_end_d  = sat_add(next_onset_q, NIGHT_LEN_V);
                        next_onset_d = sat_add(next_onset_q, PERIOD_V);
                        pending_d    = 1'b0;
                    end else if (trig_force) begin
                        state_d     = ST_FADE_TO_NIGHT;
                        night_end_d = sat_add(score15, NIGHT_LEN_V);
                    end
                end
                ST_FADE_TO_NIGHT: begin
                    if (!pause && end_hit) begin
                        state_d = ST_FADE_TO_DAY;
                    end else if (tick && !entry_q) begin
                        if ((level_q + 4'd1) >= LVL_MAX) begin
                            level_d = LVL_MAX;
                            state_d = ST_NIGHT;
                            done_d  = 1'b1;
                        end else begin
                            level_d = level_q + 4'd1;
                        end
                    end
                end
                ST_NIGHT: begin
                    level_d = LVL_MAX;
                    if (!pause && end_hit) begin
                        state_d = ST_FADE_TO_DAY;
                    end else if (trig_force) begin
                        state_d = ST_FADE_TO_DAY;
                    end
                end
                ST_FADE_TO_DAY: begin
                    // An onset reached mid-fade is remembered and launched as soon as DAY is entered.
                    if (!pause && onset_hit) begin
                        pending_d = 1'b1;
                    end
                    if (tick && !entry_q) begin
                        if (level_q <= 4'd1) begin
                            level_d = 4'd0;
                            state_d = ST_DAY;
                            done_d  = 1'b1;
                        end else begin
                            level_d = level_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_DAY;
                    level_d = 4'd0;
                end
            endcase
        end

        // The first cycle in a new state never steps the level.
        entry_d = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_DAY;
            level_q      <= 4'd0;
            next_onset_q <= PERIOD_V;
            night_end_q  <= 15'd0;
            pending_q    <= 1'b0;
            done_q       <= 1'b0;
            entry_q      <= 1'b0;
            prescaler_q  <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            next_onset_q <= next_onset_d;
            night_end_q  <= night_end_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            entry_q      <= entry_d;
            prescaler_q  <= prescaler_d;
        end
    end

    assign fade_level = level_q;
    assign night      = (state_q == ST_FADE_TO_NIGHT) || (state_q == ST_NIGHT);
    assign fading     = (state_q == ST_FADE_TO_NIGHT) || (state_q == ST_FADE_TO_DAY);
    assign done       = done_q;

endmodule

// File: tb/tb_day_night_scheduler.sv
// tb/tb_day_night_scheduler.sv - scoreboard bench for day_night_scheduler with a fast prescaler
module tb_day_night_scheduler;

    logic        clk;
    logic        rst_n;
    logic [13:0] game_score;
    logic        pause;
    logic [3:0]  fade_level;
    logic        night;
    logic        fading;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] lvl;
        logic       night;
        logic       fading;
    } exp_t;

    exp_t sb_q[$];

    day_night_scheduler #(
        .PERIOD    (700),
        .NIGHT_LEN (150),
        .DIV_BITS  (2),
        .LEVEL_MAX (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .game_score (game_score),
        .pause      (pause),
        .fade_level (fade_level),
        .night      (night),
        .fading     (fading),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] lvl, input logic n, input logic f);
        exp_t e;
        e.lvl    = lvl;
        e.night  = n;
        e.fading = f;
        sb_q.push_back(e);
    endtask

    // Each done pulse consumes one expected phase arrival.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("sb_done_level", 32'(fade_level), 32'(e.lvl));
                check_val("sb_done_night", 32'(night), 32'(e.night));
                check_val("sb_done_fading", 32'(fading), 32'(e.fading));
            end
        end
    end

    task automatic wait_level(input logic [3:0] lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (fade_level !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(fade_level === lvl), 32'd1);
    endtask

    task automatic wait_fade_end(input int budget, output int n);
        n = 0;
        while (fading === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        game_score = 14'd0;
        pause      = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_level", 32'(fade_level), 32'd0);
        check_val("rst_night", 32'(night), 32'd0);
        check_val("rst_fading", 32'(fading), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Onset at 700 and full ramp to night.
        game_score = 14'd700;
        push_exp(4'd15, 1'b1, 1'b0);
        @(negedge clk);
        check_val("onset_night", 32'(night), 32'd1);
        check_val("onset_fading", 32'(fading), 32'd1);
        check_val("onset_level", 32'(fade_level), 32'd0);
        wait_fade_end(100, n);
        check_val("ramp_up_cycles_ok", 32'(n >= 58 && n <= 61), 32'd1);
        check_val("night_level", 32'(fade_level), 32'd15);
        check_val("night_flag", 32'(night), 32'd1);

        // Night end at 850 and full ramp back to day.
        game_score = 14'd850;
        push_exp(4'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("end_night", 32'(night), 32'd0);
        check_val("end_fading", 32'(fading), 32'd1);
        check_val("end_level_held", 32'(fade_level), 32'd15);
        wait_fade_end(100, n);
        check_val("ramp_down_cycles_ok", 32'(n >= 58 && n <= 61), 32'd1);
        check_val("day_level", 32'(fade_level), 32'd0);
        check_val("day_night", 32'(night), 32'd0);

        // Second onset exactly at 1400.
        game_score = 14'd1399;
        repeat (5) @(negedge clk);
        check_val("onset_1399", 32'(night), 32'd0);
        game_score = 14'd1400;
        @(negedge clk);
        check_val("onset_1400", 32'(night), 32'd1);
        game_score = 14'd0;
        @(negedge clk);
        check_val("restart_a_level", 32'(fade_level), 32'd0);
        check_val("restart_a_night", 32'(night), 32'd0);
        check_val("restart_a_fading", 32'(fading), 32'd0);

        // Score jump 690 -> 720 still triggers; night end lands at 850.
        game_score = 14'd690;
        repeat (3) @(negedge clk);
        check_val("jump_690", 32'(night), 32'd0);
        game_score = 14'd720;
        @(negedge clk);
        check_val("jump_720", 32'(night), 32'd1);
        repeat (8) @(negedge clk);
        game_score = 14'd849;
        repeat (3) @(negedge clk);
        check_val("jump_849_night", 32'(night), 32'd1);
        check_val("jump_849_fading", 32'(fading), 32'd1);
        game_score = 14'd850;
        push_exp(4'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("jump_850_night", 32'(night), 32'd0);
        check_val("jump_850_fading", 32'(fading), 32'd1);
        wait_fade_end(80, n);
        check_val("jump_day_level", 32'(fade_level), 32'd0);

        // Restart at level 8 mid-ramp, then re-trigger.
        game_score = 14'd0;
        @(negedge clk);
        game_score = 14'd700;
        @(negedge clk);
        check_val("retrig_a_night", 32'(night), 32'd1);
        wait_level(4'd8, 60, "reach_level_8");
        game_score = 14'd0;
        @(negedge clk);
        check_val("restart_b_level", 32'(fade_level), 32'd0);
        check_val("restart_b_night", 32'(night), 32'd0);
        check_val("restart_b_fading", 32'(fading), 32'd0);
        game_score = 14'd700;
        @(negedge clk);
        check_val("retrig_b_night", 32'(night), 32'd1);
        check_val("retrig_b_fading", 32'(fading), 32'd1);

        // Pause freezes both the ramp and the night-end trigger.
        wait_level(4'd5, 40, "reach_level_5");
        pause      = 1'b1;
        game_score = 14'd850;
        repeat (100) @(negedge clk);
        check_val("pause_level", 32'(fade_level), 32'd5);
        check_val("pause_night", 32'(night), 32'd1);
        check_val("pause_fading", 32'(fading), 32'd1);
        game_score = 14'd720;
        pause      = 1'b0;
        wait_level(4'd6, 8, "pause_resume");
        check_val("resume_night", 32'(night), 32'd1);

        // Asynchronous reset mid-fade.
        wait_level(4'd12, 40, "reach_level_12");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_level", 32'(fade_level), 32'd0);
        check_val("async_rst_night", 32'(night), 32'd0);
        check_val("async_rst_fading", 32'(fading), 32'd0);
        check_val("async_rst_done", 32'(done), 32'd0);
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
